calc_input_sequencer: RTL and testbench

- Sequences the number-concatenator datapath for the UART calculator.
- Consumes decoded UART RX bytes and parses the frame `<digits A><op><digits B><'=' or CR>`.
- Feeds each operand's digits to the concatenator, closes each operand with a fin pulse, and latches each result on done.
- Hands op_a, op_b and op_code to the ALU stage with a one-cycle calc_start. Sits between uart_rx and the concatenator/ALU.

---
 rtl/calc_pkg.sv | 59 +++++
 rtl/calc_input_sequencer_if.sv | 31 +++
 rtl/seq_timer.sv | 24 ++
 rtl/calc_input_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_calc_input_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the UART calculator input sequencer: FSM states,
// ASCII byte constants, operator and error codes, and byte classifiers.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A,
        S_FIN_A,
        S_B,
        S_FIN_B,
        S_ISSUE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_code_t;

    typedef enum logic [1:0] {
        ERR_CHAR    = 2'b00,
        ERR_EMPTY   = 2'b01,
        ERR_LEN     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_operator(input logic [7:0] b);
        return (b == ASCII_PLUS) || (b == ASCII_MINUS) ||
               (b == ASCII_STAR) || (b == ASCII_SLASH);
    endfunction

    function automatic logic is_terminator(input logic [7:0] b);
        return (b == ASCII_EQ) || (b == ASCII_CR);
    endfunction

    function automatic op_code_t op_from_ascii(input logic [7:0] b);
        case (b)
            ASCII_MINUS: return OP_SUB;
            ASCII_STAR:  return OP_MUL;
            ASCII_SLASH: return OP_DIV;
            default:     return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/calc_input_sequencer_if.sv
// Bundle of UART RX, concatenator and ALU-side signals around the sequencer.
interface calc_input_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  cat_dato;
    logic        cat_num_ready;
    logic        cat_fin;
    logic        cat_rst_n;
    logic [31:0] cat_resultado;
    logic        cat_done;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_code;
    logic        calc_start;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic        rx_drop;

    modport master (
        input  rx_data, rx_done, cat_resultado, cat_done,
        output cat_dato, cat_num_ready, cat_fin, cat_rst_n,
               op_a, op_b, op_code, calc_start, busy, err, err_code, rx_drop
    );

    modport slave (
        output rx_data, rx_done, cat_resultado, cat_done,
        input  cat_dato, cat_num_ready, cat_fin, cat_rst_n,
               op_a, op_b, op_code, calc_start, busy, err, err_code, rx_drop
    );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter that sticks at zero; expired is high while it reads zero.
module seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign expired = (count_reg == '0);
endmodule

// File: rtl/calc_input_sequencer.sv
// Parses "<A><op><B><=|CR>" from UART bytes, drives the number concatenator
// digit by digit, and launches the ALU with both operands and the operator.
module calc_input_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS   = 10,
    parameter int DIGIT_GAP    = 4,
    parameter int DONE_TIMEOUT = 1024,
    parameter int RST_CYCLES   = 2
) (
    input logic                    clk,
    input logic                    reset,
    calc_input_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int GAP_W = $clog2(DIGIT_GAP + 1);
    localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);
    localparam int RST_W = $clog2(RST_CYCLES + 1);

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fin_sent_reg;
    logic [RST_W-1:0] rst_cnt_reg;
    logic [31:0]      a_hold_reg;
    op_code_t         op_pend_reg;

    logic [7:0]       cat_dato_reg;
    logic             cat_num_ready_reg;
    logic             cat_fin_reg;
    logic             cat_rst_n_reg;
    logic [31:0]      op_a_reg;
    logic [31:0]      op_b_reg;
    op_code_t         op_code_reg;
    logic             calc_start_reg;
    logic             err_reg;
    err_code_t        err_code_reg;
    logic             rx_drop_reg;

    logic             accept, drop, raise, advance, fire;
    err_code_t        err_sel;
    logic             gap_expired, tmo_expired;

    seq_timer #(.WIDTH(GAP_W)) gap_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load       (accept),
        .load_value (GAP_W'(DIGIT_GAP)),
        .expired    (gap_expired)
    );

    // Loaded one short so the error pulse lands DONE_TIMEOUT cycles after cat_fin.
    seq_timer #(.WIDTH(TMO_W)) done_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load       (fire),
        .load_value (TMO_W'(DONE_TIMEOUT - 1)),
        .expired    (tmo_expired)
    );

    always_comb begin
        accept  = 1'b0;
        drop    = 1'b0;
        raise   = 1'b0;
        err_sel = ERR_CHAR;
        advance = 1'b0;
        fire    = 1'b0;
        case (state_reg)
            S_A, S_B: begin
                if (bus.rx_done) begin
                    if (is_digit(bus.rx_data)) begin
                        if (!gap_expired) begin
                            drop = 1'b1;
                        end else if (count_reg == CNT_W'(MAX_DIGITS)) begin
                            raise   = 1'b1;
                            err_sel = ERR_LEN;
                        end else begin
                            accept = 1'b1;
                        end
                    end else if ((state_reg == S_A && is_operator(bus.rx_data)) ||
                                 (state_reg == S_B && is_terminator(bus.rx_data))) begin
                        if (count_reg != '0) begin
                            advance = 1'b1;
                        end else begin
                            raise   = 1'b1;
                            err_sel = ERR_EMPTY;
                        end
                    end else begin
                        raise   = 1'b1;
                        err_sel = ERR_CHAR;
                    end
                end
            end
            S_FIN_A, S_FIN_B: begin
                drop = bus.rx_done;
                // A done arriving with the expiring count still counts as success.
                if (!fin_sent_reg) begin
                    fire = gap_expired;
                end else if (!bus.cat_done && tmo_expired) begin
                    raise   = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end
            end
            default: drop = bus.rx_done;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= S_A;
            count_reg         <= '0;
            fin_sent_reg      <= 1'b0;
            rst_cnt_reg       <= '0;
            a_hold_reg        <= '0;
            op_pend_reg       <= OP_ADD;
            cat_dato_reg      <= '0;
            cat_num_ready_reg <= 1'b0;
            cat_fin_reg       <= 1'b0;
            cat_rst_n_reg     <= 1'b1;
            op_a_reg          <= '0;
            op_b_reg          <= '0;
            op_code_reg       <= OP_ADD;
            calc_start_reg    <= 1'b0;
            err_reg           <= 1'b0;
            err_code_reg      <= ERR_CHAR;
            rx_drop_reg       <= 1'b0;
        end else begin
            cat_num_ready_reg <= 1'b0;
            cat_fin_reg       <= 1'b0;
            calc_start_reg    <= 1'b0;
            err_reg           <= 1'b0;
            if (drop) rx_drop_reg <= 1'b1;
            if (raise) begin
                err_reg       <= 1'b1;
                err_code_reg  <= err_sel;
                cat_rst_n_reg <= 1'b0;
                rst_cnt_reg   <= RST_W'(RST_CYCLES - 1);
                count_reg     <= '0;
                state_reg     <= S_ERR;
            end else begin
                case (state_reg)
                    S_A, S_B: begin
                        if (accept) begin
                            cat_dato_reg      <= bus.rx_data - ASCII_0;
                            cat_num_ready_reg <= 1'b1;
                            count_reg         <= count_reg + CNT_W'(1);
                        end
                        if (advance) begin
                            fin_sent_reg <= 1'b0;
                            if (state_reg == S_A) begin
                                op_pend_reg <= op_from_ascii(bus.rx_data);
                                state_reg   <= S_FIN_A;
                            end else begin
                                state_reg <= S_FIN_B;
                            end
                        end
                    end
                    S_FIN_A, S_FIN_B: begin
                        if (fire) begin
                            cat_fin_reg  <= 1'b1;
                            fin_sent_reg <= 1'b1;
                        end else if (fin_sent_reg && bus.cat_done) begin
                            count_reg <= '0;
                            if (state_reg == S_FIN_A) begin
                                a_hold_reg <= bus.cat_resultado;
                                state_reg  <= S_B;
                            end else begin
                                // Outputs only change here, keeping them stable between launches.
                                op_a_reg       <= a_hold_reg;
                                op_b_reg       <= bus.cat_resultado;
                                op_code_reg    <= op_pend_reg;
                                calc_start_reg <= 1'b1;
                                state_reg      <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
                        count_reg <= '0;
                        state_reg <= S_A;
                    end
                    S_ERR: begin
                        if (rst_cnt_reg == '0) begin
                            cat_rst_n_reg <= 1'b1;
                            state_reg     <= S_A;
                        end else begin
                            rst_cnt_reg <= rst_cnt_reg - RST_W'(1);
                        end
                    end
                    default: state_reg <= S_A;
                endcase
            end
        end
    end

    assign bus.cat_dato      = cat_dato_reg;
    assign bus.cat_num_ready = cat_num_ready_reg;
    assign bus.cat_fin       = cat_fin_reg;
    assign bus.cat_rst_n     = cat_rst_n_reg;
    assign bus.op_a          = op_a_reg;
    assign bus.op_b          = op_b_reg;
    assign bus.op_code       = op_code_reg;
    assign bus.calc_start    = calc_start_reg;
    assign bus.err           = err_reg;
    assign bus.err_code      = err_code_reg;
    assign bus.rx_drop       = rx_drop_reg;
    assign bus.busy          = !(state_reg == S_A && count_reg == '0);
endmodule

// File: tb/tb_calc_input_sequencer.sv
// Scoreboard bench: stimulus pushes expected output events, a negedge monitor
// pops and compares them; a small model plays the number concatenator.
module tb_calc_input_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_input_sequencer_if bus();

    calc_input_sequencer dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    localparam int K_DIG = 0, K_FIN = 1, K_START = 2, K_ERR = 3;
    typedef struct {
        int          kind;
        int          v;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_miss = 0;
    int  cyc = 0;
    int  last_dig = 0;
    int  last_fin = 0;
    int  low_run = 0;
    bit  withhold = 1'b0;

    task automatic check(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int v, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind; e.v = v; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int v, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_event: got kind %0d value %0d expected none (cycle %0d)", kind, v, cyc);
        end else begin
            e = exp_q.pop_front();
            $display("event kind=%0d value=%0d a=%0d b=%0d cycle=%0d", kind, v, a, b, cyc);
            check("event_kind", kind, e.kind);
            check("event_value", v, e.v);
            if (kind == K_START) begin
                check("op_a", a, e.a);
                check("op_b", b, e.b);
            end
        end
    endtask

    // Concatenator model: decimal accumulate, answer three cycles after fin.
    logic [31:0] acc;
    int          dly;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc               <= '0;
            dly               <= 0;
            bus.cat_done      <= 1'b0;
            bus.cat_resultado <= '0;
        end else begin
            bus.cat_done <= 1'b0;
            if (!bus.cat_rst_n) begin
                acc <= '0;
                dly <= 0;
            end else begin
                if (bus.cat_num_ready) acc <= acc * 10 + 32'(bus.cat_dato);
                if (bus.cat_fin && !withhold) dly <= 3;
                else if (dly != 0) dly <= dly - 1;
                if (dly == 1) begin
                    bus.cat_done      <= 1'b1;
                    bus.cat_resultado <= acc;
                    acc               <= '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (bus.cat_num_ready) begin
                pop_check(K_DIG, int'(bus.cat_dato), 0, 0);
                last_dig = cyc;
            end
            if (bus.cat_fin) begin
                check("fin_after_digit_gap", longint'(cyc - last_dig >= 4), 1);
                pop_check(K_FIN, 0, 0, 0);
                last_fin = cyc;
            end
            if (bus.calc_start) pop_check(K_START, int'(bus.op_code), bus.op_a, bus.op_b);
            if (bus.err) begin
                pop_check(K_ERR, int'(bus.err_code), 0, 0);
                if (bus.err_code == 2'b11) check("timeout_latency", cyc - last_fin, 1024);
            end
            if (!bus.cat_rst_n) low_run++;
            else if (low_run != 0) begin
                check("cat_rst_n_low_cycles", low_run, 2);
                low_run = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int space);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        repeat (space - 1) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int space);
        for (int i = 0; i < s.len(); i++) send(s[i], space);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (10) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_cat_dato", bus.cat_dato, 0);
        check("rst_cat_num_ready", bus.cat_num_ready, 0);
        check("rst_cat_fin", bus.cat_fin, 0);
        check("rst_cat_rst_n", bus.cat_rst_n, 1);
        check("rst_op_a", bus.op_a, 0);
        check("rst_op_b", bus.op_b, 0);
        check("rst_op_code", bus.op_code, 0);
        check("rst_calc_start", bus.calc_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_rx_drop", bus.rx_drop, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low_run = 0;
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // "12+34=" with a 20-cycle byte spacing
        push(K_DIG, 1, 0, 0); push(K_DIG, 2, 0, 0); push(K_FIN, 0, 0, 0);
        push(K_DIG, 3, 0, 0); push(K_DIG, 4, 0, 0); push(K_FIN, 0, 0, 0);
        push(K_START, 0, 12, 34);
        send_str("12+34=", 20);
        wait_drain(200);
        check("idle_busy", bus.busy, 0);
        check("stable_op_a", bus.op_a, 12);

        // "7*" "5" CR, then "9/3="
        push(K_DIG, 7, 0, 0); push(K_FIN, 0, 0, 0);
        push(K_DIG, 5, 0, 0); push(K_FIN, 0, 0, 0); push(K_START, 2, 7, 5);
        send_str("7*", 20);
        send_str("5", 20);
        send(8'h0D, 20);
        push(K_DIG, 9, 0, 0); push(K_FIN, 0, 0, 0);
        push(K_DIG, 3, 0, 0); push(K_FIN, 0, 0, 0); push(K_START, 3, 9, 3);
        send_str("9/3=", 20);
        wait_drain(200);

        // "+5=": empty operand A, then '=' is a bad char in A; then "8-2="
        push(K_ERR, 1, 0, 0); push(K_DIG, 5, 0, 0); push(K_ERR, 0, 0, 0);
        send_str("+5=", 20);
        check("err_keeps_op_a", bus.op_a, 9);
        push(K_DIG, 8, 0, 0); push(K_FIN, 0, 0, 0);
        push(K_DIG, 2, 0, 0); push(K_FIN, 0, 0, 0); push(K_START, 1, 8, 2);
        send_str("8-2=", 20);
        wait_drain(200);

        // eleven '1' digits: the eleventh overflows
        for (int i = 0; i < 10; i++) push(K_DIG, 1, 0, 0);
        push(K_ERR, 2, 0, 0);
        for (int i = 0; i < 11; i++) send(8'h31, 20);
        wait_drain(200);

        // "4+" with cat_done withheld: timeout, and a byte dropped meanwhile
        withhold = 1'b1;
        check("drop_clear_before", bus.rx_drop, 0);
        push(K_DIG, 4, 0, 0); push(K_FIN, 0, 0, 0); push(K_ERR, 3, 0, 0);
        send(8'h34, 20);
        send(8'h2B, 100);
        check("busy_in_fin", bus.busy, 1);
        send(8'h39, 20);
        check("drop_in_fin", bus.rx_drop, 1);
        wait_drain(1500);
        withhold = 1'b0;

        reset_pulse();

        // two digits 2 cycles apart, then 'a'
        push(K_DIG, 6, 0, 0);
        send(8'h36, 2);
        send(8'h36, 20);
        check("drop_fast_digit", bus.rx_drop, 1);
        push(K_ERR, 0, 0, 0);
        send(8'h61, 20);
        wait_drain(200);

        // mid-frame reset
        push(K_DIG, 5, 0, 0);
        send(8'h35, 5);
        check("busy_mid_frame", bus.busy, 1);
        reset_pulse();
        check("no_pending_after_reset", exp_q.size(), 0);

        // recovery frame
        push(K_DIG, 1, 0, 0); push(K_FIN, 0, 0, 0);
        push(K_DIG, 1, 0, 0); push(K_FIN, 0, 0, 0); push(K_START, 0, 1, 1);
        send_str("1+1=", 20);
        wait_drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
